div_seq: RTL and testbench

- Multi-cycle radix-2 restoring integer divider for the 54-instruction CPU; it is the inverse of the combinational signed multiplier.
- Executes DIV (signed) and DIVU (unsigned) and produces a 32-bit quotient for LO and a 32-bit remainder for HI.
- Sits beside the multiplier in the execute stage. The control unit stalls the pipeline while busy=1.
- Operands are captured at start, so the inputs may change freely while the divider runs.

---
 rtl/div_seq.sv | 163 ++++++++++++++++
 tb/tb_div_seq.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_seq.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU. It produces the quotient (LO) and remainder (HI)
// 33 edges after an accepted start. Operands are captured at start, so the inputs may change during a run.
module div_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero,
  output logic [1:0]       dbg_state
);

  // Handshake: start is accepted only on an edge where busy=0, and that
  // includes the done cycle. busy stays high from the accept edge until
  // results are written. done is a one-cycle pulse after results update.
  // start while busy=1 is ignored.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [WIDTH-1:0]   dd_q, dd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               q_neg_q, q_neg_d;
  logic               r_neg_q, r_neg_d;
  logic               zero_q, zero_d;
  logic [WIDTH-1:0]   quotient_q, quotient_d;
  logic [WIDTH-1:0]   remainder_q, remainder_d;
  logic               div_zero_q, div_zero_d;
  logic               done_q, done_d;

  logic               sd, ss;
  logic [WIDTH-1:0]   dd_mag, dvs_mag;
  logic [WIDTH:0]     shifted;
  logic               trial_ge;
  logic [WIDTH-1:0]   trial_diff;

  always_comb begin
    sd      = is_signed & dividend[WIDTH-1];
    ss      = is_signed & divisor[WIDTH-1];
    dd_mag  = sd ? (~dividend + 1'b1) : dividend;
    dvs_mag = ss ? (~divisor + 1'b1) : divisor;
  end

  // The shifted partial remainder is WIDTH+1 bits wide. If its top bit is set,
  // it already exceeds any WIDTH-bit divisor, and the difference still fits in WIDTH bits.
  always_comb begin
    shifted    = {rem_q, quo_q[WIDTH-1]};
    trial_ge   = shifted[WIDTH] | (shifted[WIDTH-1:0] >= dvs_q);
    trial_diff = shifted[WIDTH-1:0] - dvs_q;
  end

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    dd_d        = dd_q;
    cnt_d       = cnt_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    zero_d      = zero_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          dvs_d   = dvs_mag;
          quo_d   = dd_mag;
          dd_d    = dividend;
          rem_d   = '0;
          cnt_d   = '0;
          q_neg_d = sd ^ ss;
          r_neg_d = sd;
          zero_d  = (divisor == '0);
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (trial_ge) begin
          rem_d = trial_diff;
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (zero_q) begin
          quotient_d  = '1;
          remainder_d = dd_q;
          div_zero_d  = 1'b1;
        end else begin
          quotient_d  = q_neg_q ? (~quo_q + 1'b1) : quo_q;
          remainder_d = r_neg_q ? (~rem_q + 1'b1) : rem_q;
          div_zero_d  = 1'b0;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      dd_q        <= '0;
      cnt_q       <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      zero_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      dd_q        <= dd_d;
      cnt_q       <= cnt_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      zero_q      <= zero_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
      done_q      <= done_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign div_zero  = div_zero_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq. It checks timing, the signed and unsigned results, divide-by-zero,
// start handling while busy or in the done cycle, and reset in the middle of an operation.
module tb_div_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_zero;
  logic [1:0]  dbg_state;

  int checks;
  int failures;

  div_seq dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives start for exactly one edge (edge N) and returns at #1 after edge N.
  task automatic drive_start(input logic [31:0] dd, input logic [31:0] dv, input logic sgn);
    @(negedge clk);
    dividend  = dd;
    divisor   = dv;
    is_signed = sgn;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    dividend  = $urandom;
    divisor   = $urandom;
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    wait_edges(2);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || div_zero !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags: busy=%b done=%b div_zero=%b, required 0 0 0", busy, done, div_zero);
    end
    checks++;
    if (quotient !== 32'h0 || remainder !== 32'h0 || dbg_state !== 2'd0) begin
      failures++;
      $display("FAIL reset_values: q=%h r=%h st=%0d, required 0 0 0", quotient, remainder, dbg_state);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_unsigned();
    int busy_cycles;
    int early_done;
    drive_start(32'd100, 32'd7, 1'b0);
    busy_cycles = busy ? 1 : 0;
    early_done  = done ? 1 : 0;
    for (int i = 1; i <= 32; i++) begin
      wait_edges(1);
      if (busy) busy_cycles++;
      if (done) early_done++;
    end
    wait_edges(1);
    checks++;
    if (busy_cycles !== 33 || early_done !== 0) begin
      failures++;
      $display("FAIL udiv_timing: busy_cycles=%0d early_done=%0d, required 33 0", busy_cycles, early_done);
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL udiv_done: done=%b busy=%b, required 1 0", done, busy);
    end
    checks++;
    if (quotient !== 32'd14 || remainder !== 32'd2 || div_zero !== 1'b0) begin
      failures++;
      $display("FAIL udiv_100_7: q=%h r=%h dz=%b, required e 2 0", quotient, remainder, div_zero);
    end
    wait_edges(1);
    checks++;
    if (done !== 1'b0 || quotient !== 32'd14 || remainder !== 32'd2) begin
      failures++;
      $display("FAIL udiv_hold: done=%b q=%h r=%h, required 0 e 2", done, quotient, remainder);
    end
  endtask

  task automatic test_signed();
    drive_start(32'hFFFFFFF9, 32'h2, 1'b1);
    wait_edges(33);
    checks++;
    if (done !== 1'b1 || quotient !== 32'hFFFFFFFD || remainder !== 32'hFFFFFFFF) begin
      failures++;
      $display("FAIL sdiv_m7_2: done=%b q=%h r=%h, required 1 fffffffd ffffffff", done, quotient, remainder);
    end
    drive_start(32'h7, 32'hFFFFFFFE, 1'b1);
    wait_edges(33);
    checks++;
    if (done !== 1'b1 || quotient !== 32'hFFFFFFFD || remainder !== 32'h1) begin
      failures++;
      $display("FAIL sdiv_7_m2: done=%b q=%h r=%h, required 1 fffffffd 1", done, quotient, remainder);
    end
  endtask

  task automatic test_edges();
    drive_start(32'h80000000, 32'hFFFFFFFF, 1'b1);
    wait_edges(33);
    checks++;
    if (quotient !== 32'h80000000 || remainder !== 32'h0 || div_zero !== 1'b0) begin
      failures++;
      $display("FAIL sdiv_overflow: q=%h r=%h dz=%b, required 80000000 0 0", quotient, remainder, div_zero);
    end
    drive_start(32'hFFFFFFFF, 32'h10, 1'b0);
    wait_edges(33);
    checks++;
    if (quotient !== 32'h0FFFFFFF || remainder !== 32'hF) begin
      failures++;
      $display("FAIL udiv_max_16: q=%h r=%h, required 0fffffff f", quotient, remainder);
    end
  endtask

  task automatic test_div_zero();
    drive_start(32'd5, 32'd0, 1'b0);
    wait_edges(33);
    checks++;
    if (done !== 1'b1 || quotient !== 32'hFFFFFFFF || remainder !== 32'd5 || div_zero !== 1'b1) begin
      failures++;
      $display("FAIL udiv_zero: done=%b q=%h r=%h dz=%b, required 1 ffffffff 5 1", done, quotient, remainder, div_zero);
    end
    drive_start(32'd5, 32'd0, 1'b1);
    wait_edges(33);
    checks++;
    if (quotient !== 32'hFFFFFFFF || remainder !== 32'd5 || div_zero !== 1'b1) begin
      failures++;
      $display("FAIL sdiv_zero: q=%h r=%h dz=%b, required ffffffff 5 1", quotient, remainder, div_zero);
    end
    drive_start(32'd9, 32'd3, 1'b0);
    wait_edges(33);
    checks++;
    if (quotient !== 32'd3 || remainder !== 32'd0 || div_zero !== 1'b0) begin
      failures++;
      $display("FAIL zero_clear: q=%h r=%h dz=%b, required 3 0 0", quotient, remainder, div_zero);
    end
  endtask

  task automatic test_ignore_start();
    drive_start(32'd100, 32'd7, 1'b0);
    wait_edges(4);
    drive_start(32'd50, 32'd5, 1'b1);
    wait_edges(28);
    checks++;
    if (done !== 1'b1 || quotient !== 32'd14 || remainder !== 32'd2) begin
      failures++;
      $display("FAIL ignore_start: done=%b q=%h r=%h, required 1 e 2", done, quotient, remainder);
    end
    wait_edges(1);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL ignore_no_rerun: busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  task automatic test_back_to_back();
    drive_start(32'd100, 32'd7, 1'b0);
    wait_edges(33);
    checks++;
    if (done !== 1'b1 || quotient !== 32'd14) begin
      failures++;
      $display("FAIL b2b_first: done=%b q=%h, required 1 e", done, quotient);
    end
    drive_start(32'hFFFFFFFF, 32'h10, 1'b0);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL b2b_accept: busy=%b done=%b, required 1 0", busy, done);
    end
    wait_edges(32);
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL b2b_not_early: done=%b busy=%b, required 0 1", done, busy);
    end
    wait_edges(1);
    checks++;
    if (done !== 1'b1 || quotient !== 32'h0FFFFFFF || remainder !== 32'hF) begin
      failures++;
      $display("FAIL b2b_second: done=%b q=%h r=%h, required 1 0fffffff f", done, quotient, remainder);
    end
  endtask

  task automatic test_reset_mid();
    int done_seen;
    drive_start(32'd100, 32'd7, 1'b0);
    wait_edges(9);
    @(negedge clk);
    reset = 1'b1;
    wait_edges(1);
    checks++;
    if (busy !== 1'b0 || quotient !== 32'h0 || remainder !== 32'h0 || dbg_state !== 2'd0) begin
      failures++;
      $display("FAIL reset_mid: busy=%b q=%h r=%h st=%0d, required 0 0 0 0", busy, quotient, remainder, dbg_state);
    end
    @(negedge clk);
    reset = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 30; i++) begin
      wait_edges(1);
      if (done) done_seen++;
    end
    checks++;
    if (done_seen !== 0) begin
      failures++;
      $display("FAIL reset_no_done: done pulses=%0d, required 0", done_seen);
    end
    drive_start(32'd100, 32'd7, 1'b0);
    wait_edges(33);
    checks++;
    if (done !== 1'b1 || quotient !== 32'd14 || remainder !== 32'd2) begin
      failures++;
      $display("FAIL reset_fresh: done=%b q=%h r=%h, required 1 e 2", done, quotient, remainder);
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = 32'h0;
    divisor   = 32'h0;
    test_reset();
    test_unsigned();
    test_signed();
    test_edges();
    test_div_zero();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
